pool_window_gen: RTL and testbench
==================================

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

Interface
REQ-001 Parameter NBITS, default 32: bits per activation element, two's complement.
REQ-002 Parameter NFMAPS, default 32: feature maps carried in parallel per pixel.
REQ-003 Parameter KER_SIZE, default 2: pooling window edge; only 2 is supported, stride equals KER_SIZE.
REQ-004 Parameter IMG_W, default 16: pixels per row, at least 2.
REQ-005 Parameter IMG_H, default 16: rows per frame, at least 2.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rstn, input, 1: reset, synchronous and active-low.
REQ-008 Port in_valid, input, 1: in_act carries one pixel this cycle.
REQ-009 Port in_sof, input, 1: qualified by in_valid; marks the pixel as row 0, column 0 of a new frame.
REQ-010 Port in_act, input, NBITS*NFMAPS: pixel, fmap i at bits [(i+1)*NBITS-1 : i*NBITS].
REQ-011 Port out_valid, output, 1: single-cycle pulse; out_window holds a complete window.
REQ-012 Port out_window, output, NBITS*KER_SIZE*KER_SIZE*NFMAPS: fmap i slice at [(i+1)*4*NBITS-1 : i*4*NBITS]; within a slice, element 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right, element k at slice bits [(k+1)*NBITS-1 : k*NBITS].
REQ-013 Port frame_done, output, 1: single-cycle pulse concurrent with out_valid for the last window of a frame.

Function
REQ-014 Input is raster order, row-major; col counter (0..IMG_W-1) and row counter (0..IMG_H-1) advance only on in_valid cycles.
REQ-015 Col wraps to 0 after IMG_W-1 and increments row; row wraps to 0 after IMG_H-1 (next frame starts without in_sof).
REQ-016 in_valid with in_sof forces the current pixel to position (0,0) regardless of counter state; counters continue from (0,1).
REQ-017 Even-row pixels are written to a one-row line buffer of IMG_W entries at index col; in_valid low causes no write.
REQ-018 Odd-row, even-col pixels are held in a single-pixel register as bottom-left candidate.
REQ-019 Odd-row, odd-col pixel completes a window: top-left = linebuf[col-1], top-right = linebuf[col], bottom-left = held register, bottom-right = in_act.
REQ-020 Window is registered: out_window and out_valid update exactly 1 cycle after the completing input cycle; out_window holds its value until the next window.
REQ-021 out_valid is high only the cycle after a completing pixel; gaps in in_valid delay windows but never drop or duplicate them.
REQ-022 Odd IMG_W: last column ignored for window formation; odd IMG_H: last row ignored; counters still wrap at IMG_W-1 / IMG_H-1.
REQ-023 frame_done asserts with out_valid for the window whose bottom-right is at row 2*floor(IMG_H/2)-1, col 2*floor(IMG_W/2)-1.
REQ-024 No output backpressure; downstream accepts every out_valid pulse.
REQ-025 Element values pass through unmodified; no arithmetic on data.

Reset
REQ-026 While rstn low at a clock edge: col, row <= 0; out_valid, frame_done <= 0; out_window <= 0; held register <= 0.
REQ-027 Line buffer contents need not be reset; no window is emitted before its rows are rewritten after reset.
REQ-028 Reset mid-frame discards partial windows; first pixel after reset is treated as (0,0).

Verification
REQ-029 IMG_W=4, IMG_H=4, NBITS=8, NFMAPS=1, continuous pixels value=row*4+col, sof on pixel 0 -> out_valid the cycle after pixel 5, window elements {0,1,4,5}; next after pixel 7 {2,3,6,7}.
REQ-030 Same frame continued -> windows {8,9,12,13} then {10,11,14,15}; frame_done only with the last; exactly 4 out_valid pulses.
REQ-031 Same frame with in_valid low every other cycle -> identical 4 windows, each 1 cycle after its completing pixel.
REQ-032 IMG_W=5, IMG_H=3, pixels row*5+col -> exactly 2 windows {0,1,5,6}, {2,3,7,8}; frame_done with second; pixels of col 4 and row 2 never appear.
REQ-033 rstn low for 1 cycle after pixel 6 of a 4x4 frame, then a fresh frame 100+row*4+col -> first window {100,101,104,105}; no window from pre-reset data.
REQ-034 in_sof asserted at pixel 9 mid-frame with values 200+row*4+col -> counters resync; first window {200,201,204,205}.

Source files
------------

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 pooling window generator: turns a raster pixel stream into
// complete 2x2 windows per feature map, using one line buffer and one held pixel.
module pool_window_gen #(
    parameter int NBITS    = 32,
    parameter int NFMAPS   = 32,
    parameter int KER_SIZE = 2,
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    in_valid,
    input  logic                                    in_sof,
    input  logic [NBITS*NFMAPS-1:0]                 in_act,
    output logic                                    out_valid,
    output logic [NBITS*KER_SIZE*KER_SIZE*NFMAPS-1:0] out_window,
    output logic                                    frame_done
);

    localparam int PW    = NBITS * NFMAPS;
    localparam int NELEM = KER_SIZE * KER_SIZE;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_WEND = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_WEND = RW'(2 * (IMG_H / 2) - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [PW-1:0] r_linebuf [IMG_W];
    logic [PW-1:0] r_bl;

    logic [CW-1:0] w_col, w_col_nxt;
    logic [RW-1:0] w_row, w_row_nxt;
    logic [PW-1:0] w_tl, w_tr;
    logic          w_complete, w_last;
    logic [NBITS*NELEM*NFMAPS-1:0] w_window;

    // in_sof overrides the counters so the current pixel lands at (0,0).
    always_comb begin
        w_col      = in_sof ? '0 : r_col;
        w_row      = in_sof ? '0 : r_row;
        w_col_nxt  = (w_col == COL_LAST) ? '0 : w_col + CW'(1);
        w_row_nxt  = w_row;
        if (w_col == COL_LAST) begin
            w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end
        // Odd row and odd column: this pixel is the bottom-right of a window.
        w_complete = in_valid & w_row[0] & w_col[0];
        w_last     = (w_row == ROW_WEND) && (w_col == COL_WEND);
        w_tl       = r_linebuf[w_col - CW'(1)];
        w_tr       = r_linebuf[w_col];
        w_window   = '0;
        for (int i = 0; i < NFMAPS; i++) begin
            w_window[(i*NELEM + 0)*NBITS +: NBITS] = w_tl[i*NBITS +: NBITS];
            w_window[(i*NELEM + 1)*NBITS +: NBITS] = w_tr[i*NBITS +: NBITS];
            w_window[(i*NELEM + 2)*NBITS +: NBITS] = r_bl[i*NBITS +: NBITS];
            w_window[(i*NELEM + 3)*NBITS +: NBITS] = in_act[i*NBITS +: NBITS];
        end
    end

    // Line buffer holds data only; row 0 is always rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_valid && !w_row[0]) begin
            r_linebuf[w_col] <= in_act;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_col      <= '0;
            r_row      <= '0;
            r_bl       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else begin
            out_valid  <= w_complete;
            frame_done <= w_complete & w_last;
            if (in_valid) begin
                r_col <= w_col_nxt;
                r_row <= w_row_nxt;
                if (w_row[0] && !w_col[0]) begin
                    r_bl <= in_act;
                end
            end
            if (w_complete) begin
                out_window <= w_window;
            end
        end
    end

endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: a 4x4 and a 5x3 instance share one input stream and
// are compared each cycle against a frame-array reference model plus directed windows.
module tb_pool_window_gen;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_sof;
    logic [15:0] in_act;
    logic        a_valid, a_done, b_valid, b_done;
    logic [63:0] a_win, b_win;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pool_window_gen #(.NBITS(8), .NFMAPS(2), .KER_SIZE(2), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_act(in_act),
        .out_valid(a_valid), .out_window(a_win), .frame_done(a_done));

    pool_window_gen #(.NBITS(8), .NFMAPS(2), .KER_SIZE(2), .IMG_W(5), .IMG_H(3)) dut_b (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_act(in_act),
        .out_valid(b_valid), .out_window(b_win), .frame_done(b_done));

    // Reference model: pixel index within frame, and the frame as a 2-D array.
    int          m_W [2] = '{4, 5};
    int          m_H [2] = '{4, 3};
    int          m_p [2];
    logic        m_v [2];
    logic        m_d [2];
    logic [63:0] m_w [2];
    logic [15:0] frm [2][16][16];

    logic [131:0] exp_log [$];
    logic [131:0] obs_log [$];
    logic [64:0]  win_a [$];
    logic [64:0]  win_b [$];

    logic [31:0] EXP4 [4] = '{{8'd5, 8'd4, 8'd1, 8'd0}, {8'd7, 8'd6, 8'd3, 8'd2},
                              {8'd13, 8'd12, 8'd9, 8'd8}, {8'd15, 8'd14, 8'd11, 8'd10}};

    task automatic clear_logs();
        exp_log.delete(); obs_log.delete(); win_a.delete(); win_b.delete();
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        int r, c;
        logic [15:0] px [4];
        in_valid = v; in_sof = s; in_act = d;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0;
            m_d[k] = 1'b0;
            if (!rstn) begin
                m_p[k] = 0;
                m_w[k] = '0;
            end else if (v) begin
                if (s) m_p[k] = 0;
                r = m_p[k] / m_W[k];
                c = m_p[k] % m_W[k];
                frm[k][r][c] = d;
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    px[0] = frm[k][r-1][c-1];
                    px[1] = frm[k][r-1][c];
                    px[2] = frm[k][r][c-1];
                    px[3] = frm[k][r][c];
                    for (int f = 0; f < 2; f++)
                        for (int e = 0; e < 4; e++)
                            m_w[k][(f*4+e)*8 +: 8] = px[e][f*8 +: 8];
                    m_v[k] = 1'b1;
                    m_d[k] = (r == 2*(m_H[k]/2) - 1) && (c == 2*(m_W[k]/2) - 1);
                end
                m_p[k] = (m_p[k] + 1) % (m_W[k] * m_H[k]);
            end
        end
        #1;
        exp_log.push_back({m_v[0], m_d[0], m_w[0], m_v[1], m_d[1], m_w[1]});
        obs_log.push_back({a_valid, a_done, a_win, b_valid, b_done, b_win});
        if (a_valid === 1'b1) win_a.push_back({a_done, a_win});
        if (b_valid === 1'b1) win_b.push_back({b_done, b_win});
    endtask

    task automatic test_reset();
        clear_logs();
        rstn = 1'b0;
        drive(1'b1, 1'b0, 16'h1234);
        drive(1'b0, 1'b0, 16'h0);
        n_tests++;
        if ({a_valid, a_done, a_win, b_valid, b_done, b_win} !== 132'd0) begin
            n_fail++;
            $display("FAIL reset_state got %h expected 0", {a_valid, a_done, a_win, b_valid, b_done, b_win});
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL reset_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        clear_logs();
        for (int p = 0; p < 16; p++) drive(1'b1, p == 0, {8'($urandom), 8'(p)});
        drive(1'b0, 1'b0, 16'h0);
        n_tests++;
        if (obs_log[5][131] !== 1'b1 || obs_log[4][131] !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency got %b%b expected 10", obs_log[5][131], obs_log[4][131]);
        end
        n_tests++;
        if (win_a.size() != 4) begin
            n_fail++;
            $display("FAIL basic_count got %0d expected 4", win_a.size());
        end
        for (int i = 0; i < win_a.size() && i < 4; i++) begin
            n_tests++;
            if (win_a[i][31:0] !== EXP4[i] || win_a[i][64] !== (i == 3)) begin
                n_fail++;
                $display("FAIL basic_win%0d got %h done %b expected %h done %b",
                         i, win_a[i][31:0], win_a[i][64], EXP4[i], i == 3);
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL basic_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        for (int p = 0; p < 16; p++) begin
            drive(1'b1, p == 0, {8'($urandom), 8'(p)});
            drive(1'b0, 1'b1, 16'($urandom));
        end
        n_tests++;
        if (win_a.size() != 4) begin
            n_fail++;
            $display("FAIL gaps_count got %0d expected 4", win_a.size());
        end
        for (int i = 0; i < win_a.size() && i < 4; i++) begin
            n_tests++;
            if (win_a[i][31:0] !== EXP4[i] || win_a[i][64] !== (i == 3)) begin
                n_fail++;
                $display("FAIL gaps_win%0d got %h expected %h", i, win_a[i][31:0], EXP4[i]);
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL gaps_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_odd_dims();
        logic [31:0] e0, e1;
        e0 = {8'd6, 8'd5, 8'd1, 8'd0};
        e1 = {8'd8, 8'd7, 8'd3, 8'd2};
        clear_logs();
        for (int p = 0; p < 15; p++) drive(1'b1, p == 0, {8'($urandom), 8'(p)});
        drive(1'b0, 1'b0, 16'h0);
        n_tests++;
        if (win_b.size() != 2) begin
            n_fail++;
            $display("FAIL odd_count got %0d expected 2", win_b.size());
        end
        if (win_b.size() >= 2) begin
            n_tests++;
            if (win_b[0][31:0] !== e0 || win_b[0][64] !== 1'b0 ||
                win_b[1][31:0] !== e1 || win_b[1][64] !== 1'b1) begin
                n_fail++;
                $display("FAIL odd_wins got %h %h expected %h %h", win_b[0], win_b[1], {1'b0, e0}, {1'b1, e1});
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL odd_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        clear_logs();
        for (int p = 0; p < 7; p++) drive(1'b1, p == 0, {8'($urandom), 8'(p)});
        rstn = 1'b0;
        drive(1'b1, 1'b0, 16'($urandom));
        rstn = 1'b1;
        win_a.delete();
        for (int p = 0; p < 16; p++) drive(1'b1, 1'b0, {8'($urandom), 8'(100 + p)});
        drive(1'b0, 1'b0, 16'h0);
        n_tests++;
        if (win_a.size() != 4) begin
            n_fail++;
            $display("FAIL mid_reset_count got %0d expected 4", win_a.size());
        end else begin
            n_tests++;
            if (win_a[0][31:0] !== {8'd105, 8'd104, 8'd101, 8'd100}) begin
                n_fail++;
                $display("FAIL mid_reset_first got %h expected 69686564", win_a[0][31:0]);
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL mid_reset_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_sof_resync();
        clear_logs();
        for (int p = 0; p < 9; p++) drive(1'b1, p == 0, {8'($urandom), 8'(p)});
        for (int p = 0; p < 16; p++) drive(1'b1, p == 0, {8'($urandom), 8'(200 + p)});
        drive(1'b0, 1'b0, 16'h0);
        n_tests++;
        if (win_a.size() != 6) begin
            n_fail++;
            $display("FAIL sof_count got %0d expected 6", win_a.size());
        end else begin
            n_tests++;
            if (win_a[2][31:0] !== {8'd205, 8'd204, 8'd201, 8'd200}) begin
                n_fail++;
                $display("FAIL sof_first got %h expected cdccc9c8", win_a[2][31:0]);
            end
        end
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL sof_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    task automatic test_random();
        logic v, s;
        clear_logs();
        for (int n = 0; n < 600; n++) begin
            rstn = (n != 300);
            v = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 49) == 0);
            drive(v, s, 16'($urandom));
        end
        rstn = 1'b1;
        for (int i = 0; i < obs_log.size(); i++) begin
            n_tests++;
            if (obs_log[i] !== exp_log[i]) begin
                n_fail++;
                $display("FAIL random_log cycle %0d got %h expected %h", i, obs_log[i], exp_log[i]);
            end
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_act = '0;
        m_p = '{0, 0};
        m_w = '{64'd0, 64'd0};
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_odd_dims();
        test_mid_reset();
        test_sof_resync();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
